// File: rtl/vga_fb_sched_if.sv
// Host-write and picture-memory port bundle for vga_fb_sched.
// The scheduler is the slave; the host/memory side is the master.
interface vga_fb_sched_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic [15:0]       mem_rdata;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output mem_rdata,
    input  wr_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  mem_rdata,
    output wr_ready,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );
endinterface

// File: rtl/vga_fb_sched.sv
// Shares one single-port picture memory between per-pixel display reads and queued host
// writes. Display reads always win; writes drain from a 4-entry FIFO outside the window.
module vga_fb_sched #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned PIC_X  = 0,
  parameter int unsigned PIC_Y  = 0,
  parameter int unsigned PIC_W  = 100,
  parameter int unsigned PIC_H  = 100,
  parameter int unsigned ADDR_W = 14,
  parameter logic [15:0] BG     = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs,
  input  logic             vs,
  input  logic [WIDTH-1:0] line_coo,
  input  logic [WIDTH-1:0] ver_coo,
  vga_fb_sched_if.slave    bus,
  output logic [15:0]      rgb_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic [2:0]       fifo_cnt
);
  localparam int unsigned Depth = 4;
  localparam logic [WIDTH:0] XLo = (WIDTH+1)'(PIC_X);
  localparam logic [WIDTH:0] YLo = (WIDTH+1)'(PIC_Y);
  localparam logic [WIDTH:0] XLen = (WIDTH+1)'(PIC_W);
  localparam logic [WIDTH:0] YLen = (WIDTH+1)'(PIC_H);
  localparam logic [2:0] CntFull = 3'(Depth);

  typedef enum logic [1:0] {OpIdle, OpRead, OpWrite} op_e;

  op_e               r_op;
  op_e               w_op;
  logic              w_in_pic;
  logic              w_origin;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [WIDTH:0]    w_dx;
  logic [WIDTH:0]    w_dy;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] r_fifo_addr [Depth];
  logic [15:0]       r_fifo_data [Depth];
  logic [1:0]        r_wp;
  logic [1:0]        r_rp;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_d;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr_d;
  logic [15:0]       r_mem_wdata;
  logic [15:0]       w_mem_wdata_d;
  logic              r_pic1;
  logic              r_pic2;
  logic [2:0]        r_hs_pipe;
  logic [2:0]        r_vs_pipe;
  logic [15:0]       r_rgb;

  // Offset from the window edge; coordinates left of/above the window wrap to a large value,
  // so one unsigned compare checks both bounds.
  assign w_dx     = {1'b0, line_coo} - XLo;
  assign w_dy     = {1'b0, ver_coo} - YLo;
  assign w_in_pic = (w_dx < XLen) && (w_dy < YLen);

  // The frame origin restarts the count combinationally so a window at (0,0) reads address 0
  // on its very first pixel; the register then advances past every in-picture pixel.
  assign w_origin  = (line_coo == '0) && (ver_coo == '0);
  assign w_rd_addr = w_origin ? '0 : r_rd_addr;

  assign w_empty      = (r_cnt == 3'd0);
  assign bus.wr_ready = (r_cnt != CntFull);
  assign w_push       = bus.wr_valid && bus.wr_ready;
  assign w_pop        = (w_op == OpWrite);
  assign w_cnt_d      = r_cnt + 3'(w_push) - 3'(w_pop);

  always_comb begin
    w_op          = OpIdle;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    if (w_in_pic) begin
      w_op = OpRead;
    end else if (!w_empty) begin
      w_op = OpWrite;
    end
    unique case (w_op)
      OpRead: begin
        w_mem_addr_d = w_rd_addr;
      end
      OpWrite: begin
        w_mem_addr_d  = r_fifo_addr[r_rp];
        w_mem_wdata_d = r_fifo_data[r_rp];
      end
      default: begin
      end
    endcase
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wp] <= bus.wr_addr;
      r_fifo_data[r_wp] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= OpIdle;
      r_rd_addr   <= '0;
      r_wp        <= 2'd0;
      r_rp        <= 2'd0;
      r_cnt       <= 3'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 16'h0000;
      r_pic1      <= 1'b0;
      r_pic2      <= 1'b0;
      r_hs_pipe   <= 3'b111;
      r_vs_pipe   <= 3'b111;
      r_rgb       <= 16'h0000;
    end else begin
      r_op        <= w_op;
      r_rd_addr   <= w_rd_addr + ADDR_W'(w_in_pic);
      r_cnt       <= w_cnt_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      if (w_push) begin
        r_wp <= r_wp + 2'd1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 2'd1;
      end
      // S1 issues the command, S2 covers memory latency, S3 selects picture or background.
      r_pic1    <= w_in_pic;
      r_pic2    <= r_pic1;
      r_rgb     <= r_pic2 ? bus.mem_rdata : BG;
      r_hs_pipe <= {r_hs_pipe[1:0], hs};
      r_vs_pipe <= {r_vs_pipe[1:0], vs};
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = (r_op == OpWrite);
  assign rgb_o         = r_rgb;
  assign hs_o          = r_hs_pipe[2];
  assign vs_o          = r_vs_pipe[2];
  assign fifo_cnt      = r_cnt;
endmodule

// File: tb/tb_vga_fb_sched.sv
// Directed bench for vga_fb_sched: 4x2 window at (2,1) on a 12x6 raster (10x4 active),
// memory returning data equal to the address, with host writes queued around the window.
module tb_vga_fb_sched;
  localparam int unsigned AW = 14;
  localparam logic [15:0] BG = 16'hF81F;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hs;
  logic       vs;
  logic [9:0] line_coo;
  logic [9:0] ver_coo;
  logic [15:0] rgb_o;
  logic        hs_o;
  logic        vs_o;
  logic [2:0]  fifo_cnt;

  vga_fb_sched_if #(.ADDR_W(AW)) bus_if ();

  vga_fb_sched #(
    .WIDTH (10),
    .PIC_X (2),
    .PIC_Y (1),
    .PIC_W (4),
    .PIC_H (2),
    .ADDR_W(AW),
    .BG    (BG)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hs      (hs),
    .vs      (vs),
    .line_coo(line_coo),
    .ver_coo (ver_coo),
    .bus     (bus_if.slave),
    .rgb_o   (rgb_o),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  // Memory returns its own address one clock after it is presented.
  always_ff @(posedge clk) bus_if.mem_rdata <= 16'(bus_if.mem_addr);

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit skip     = 1'b0;

  wr_t host_q[$];
  wr_t sb[$];

  bit            h_ok   [0:511];
  bit            h_pic  [0:511];
  bit            h_hs   [0:511];
  bit            h_vs   [0:511];
  logic [15:0]   h_rgb  [0:511];
  logic [AW-1:0] h_addr [0:511];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit in_win(input int x, input int y);
    return (x >= 2) && (x < 6) && (y >= 1) && (y < 3);
  endfunction

  task automatic point_checks(input int f, input int x, input int y);
    if (f == 0 && x == 1 && y == 0) begin
      check_val("post_rst_cnt", 32'(fifo_cnt), 32'd0);
      check_val("post_rst_ready", 32'(bus_if.wr_ready), 32'd1);
      check_val("post_rst_we", 32'(bus_if.mem_we), 32'd0);
    end
    if (f == 1 && y == 3) begin
      if (x == 1) check_val("drain_cnt_a", 32'(fifo_cnt), 32'd1);
      if (x == 2) begin
        check_val("drain_cnt_b", 32'(fifo_cnt), 32'd1);
        check_val("drain_we0", 32'(bus_if.mem_we), 32'd1);
        check_val("drain_addr0", 32'(bus_if.mem_addr), 32'h10);
        check_val("drain_data0", 32'(bus_if.mem_wdata), 32'hABCD);
      end
      if (x == 3) begin
        check_val("drain_cnt_c", 32'(fifo_cnt), 32'd0);
        check_val("drain_we1", 32'(bus_if.mem_we), 32'd1);
        check_val("drain_addr1", 32'(bus_if.mem_addr), 32'h11);
        check_val("drain_data1", 32'(bus_if.mem_wdata), 32'h1234);
      end
      if (x == 4) check_val("drain_we_end", 32'(bus_if.mem_we), 32'd0);
    end
    if (f == 2 && y == 1) begin
      if (x == 6) begin
        check_val("full_ready", 32'(bus_if.wr_ready), 32'd0);
        check_val("full_cnt", 32'(fifo_cnt), 32'd4);
        check_val("full_no_we", 32'(bus_if.mem_we), 32'd0);
      end
      if (x == 7) begin
        check_val("exit_we", 32'(bus_if.mem_we), 32'd1);
        check_val("exit_addr", 32'(bus_if.mem_addr), 32'h20);
        check_val("exit_data", 32'(bus_if.mem_wdata), 32'hC000);
        check_val("exit_ready", 32'(bus_if.wr_ready), 32'd1);
        check_val("exit_cnt", 32'(fifo_cnt), 32'd3);
      end
      if (x == 11) begin
        check_val("fifth_addr", 32'(bus_if.mem_addr), 32'h24);
        check_val("fifth_cnt", 32'(fifo_cnt), 32'd0);
      end
    end
    if (f == 3) begin
      if (x == 6 && y == 1) check_val("pre_rst_cnt", 32'(fifo_cnt), 32'd3);
      if (x == 7 && y == 1) begin
        check_val("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
        check_val("mid_rst_ready", 32'(bus_if.wr_ready), 32'd1);
        check_val("mid_rst_we", 32'(bus_if.mem_we), 32'd0);
        check_val("mid_rst_addr", 32'(bus_if.mem_addr), 32'd0);
        check_val("mid_rst_rgb", 32'(rgb_o), 32'd0);
        check_val("mid_rst_hs", 32'(hs_o), 32'd1);
        check_val("mid_rst_vs", 32'(vs_o), 32'd1);
      end
      if (x == 8 && y == 1) check_val("mid_rst_rgb_bg", 32'(rgb_o), 32'(BG));
      if (x == 11 && y == 3) check_val("mid_rst_cnt_late", 32'(fifo_cnt), 32'd0);
    end
  endtask

  task automatic do_cycle(input int f, input int x, input int y);
    bit pic;
    bit rst_now;
    line_coo = 10'(x);
    ver_coo  = 10'(y);
    hs       = (x != 10);
    vs       = (y != 4);
    rst_now  = (f == 3 && x == 6 && y == 1);
    rst_n    = !rst_now;
    if (f == 1 && x == 0 && y == 3) begin
      host_q.push_back(wr_t'{a: 14'h10, d: 16'hABCD});
      host_q.push_back(wr_t'{a: 14'h11, d: 16'h1234});
    end
    if (f == 2 && x == 2 && y == 1)
      for (int i = 0; i < 5; i++) host_q.push_back(wr_t'{a: 14'(32 + i), d: 16'(16'hC000 + i)});
    if (f == 3 && x == 2 && y == 1)
      for (int i = 0; i < 3; i++) host_q.push_back(wr_t'{a: 14'(48 + i), d: 16'(16'hE000 + i)});
    bus_if.wr_valid = (host_q.size() != 0);
    if (host_q.size() != 0) begin
      bus_if.wr_addr = host_q[0].a;
      bus_if.wr_data = host_q[0].d;
    end
    pic         = in_win(x, y);
    h_ok[cyc]   = !skip;
    h_pic[cyc]  = pic;
    h_hs[cyc]   = (x != 10);
    h_vs[cyc]   = (y != 4);
    h_addr[cyc] = pic ? 14'((y - 1) * 4 + (x - 2)) : 14'd0;
    h_rgb[cyc]  = pic ? 16'((y - 1) * 4 + (x - 2)) : BG;

    @(negedge clk);
    if (cyc >= 3 && h_ok[cyc-3]) begin
      check_val("rgb", 32'(rgb_o), 32'(h_rgb[cyc-3]));
      check_val("hs_o", 32'(hs_o), 32'(h_hs[cyc-3]));
      check_val("vs_o", 32'(vs_o), 32'(h_vs[cyc-3]));
    end
    if (cyc >= 1 && h_ok[cyc-1] && h_pic[cyc-1]) begin
      check_val("read_we", 32'(bus_if.mem_we), 32'd0);
      check_val("read_addr", 32'(bus_if.mem_addr), 32'(h_addr[cyc-1]));
    end
    if (bus_if.mem_we) begin
      check_val("we_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        check_val("wr_addr_order", 32'(bus_if.mem_addr), 32'(sb[0].a));
        check_val("wr_data_order", 32'(bus_if.mem_wdata), 32'(sb[0].d));
        void'(sb.pop_front());
      end
    end
    point_checks(f, x, y);
    if (bus_if.wr_valid && bus_if.wr_ready && rst_n) sb.push_back(host_q.pop_front());
    if (rst_now) begin
      host_q.delete();
      sb.delete();
      skip = 1'b1;
      h_ok[cyc] = 1'b0;
      if (cyc >= 1) h_ok[cyc-1] = 1'b0;
      if (cyc >= 2) h_ok[cyc-2] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n           = 1'b0;
    hs              = 1'b1;
    vs              = 1'b1;
    line_coo        = 10'd11;
    ver_coo         = 10'd5;
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = 14'h3F;
    bus_if.wr_data  = 16'hDEAD;
    for (int i = 0; i < 512; i++) h_ok[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_ready", 32'(bus_if.wr_ready), 32'd1);
      check_val("rst_cnt", 32'(fifo_cnt), 32'd0);
      check_val("rst_we", 32'(bus_if.mem_we), 32'd0);
      check_val("rst_rgb", 32'(rgb_o), 32'd0);
      check_val("rst_hs", 32'(hs_o), 32'd1);
      check_val("rst_vs", 32'(vs_o), 32'd1);
    end
    rst_n           = 1'b1;
    bus_if.wr_valid = 1'b0;
    for (int f = 0; f < 5; f++) begin
      skip = 1'b0;
      for (int y = 0; y < 6; y++)
        for (int x = 0; x < 12; x++) do_cycle(f, x, y);
    end
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
